scratchpad_copier: RTL and testbench
====================================

# scratchpad_copier

Memory-side initiator for the scratchpad port: a small copy engine that, on a start command, reads elements from a source range of the scratchpad and writes them to a destination range through the same `en`/`write`/`addr`/`len`/`wdata`/`rdata` interface the scratchpad responds on. It sits between a control source (test harness or core CSR) and one scratchpad instance, owning that port exclusively while busy. Range and alignment are validated at start; bad commands finish immediately with an error and never touch memory.

## Interface
Parameters:
- `SCRATCHPAD_BASE`, 16, byte address of the first scratchpad byte
- `SCRATCHPAD_SIZE`, 8, scratchpad size in bytes
- `READ_LATENCY`, 1, cycles from a read-enable cycle to valid `mem_rdata` (≥1)

Ports:
- `clk` in 1: sole clock, rising edge
- `rst_l` in 1: reset, asynchronous, active-low
- `start` in 1: command strobe, sampled only in IDLE
- `src_addr` in 64: absolute source byte address
- `dst_addr` in 64: absolute destination byte address
- `byte_count` in 32: bytes to copy
- `size` in 2: element size, len encoding (00 byte, 01 half, 10 word, 11 double)
- `busy` out 1: command in progress (high from accept through DONE)
- `done` out 1: one-cycle completion pulse
- `error` out 1: last command rejected; held until next accepted start
- `mem_en`, `mem_write` out 1: scratchpad enable / write
- `mem_addr` out 64, `mem_len` out 2, `mem_wdata` out 64: scratchpad request
- `mem_rdata` in 64: scratchpad read data

## Operation
- States: IDLE, READ, WAIT, WRITE, DONE.
- IDLE: on `start`, latch all command inputs, clear `error`, check validity:
  - `byte_count` multiple of 2^size
  - src and dst windows satisfy addr ≥ BASE and addr+byte_count ≤ BASE+SIZE, computed in 65 bits
  - On failure: set `error`, go to DONE. If `byte_count`=0 and valid: go to DONE. Otherwise go to READ.
- READ: one cycle with `mem_en`=1, `mem_write`=0, `mem_addr`=current src, `mem_len`=size. Then go to WAIT.
- WAIT: lasts READ_LATENCY cycles. On the last WAIT cycle, capture `mem_rdata` masked to 8·2^size low bits (upper bits zero). Then go to WRITE.
- WRITE: one cycle with `mem_en`=1, `mem_write`=1, `mem_addr`=current dst, `mem_wdata`=captured data.
  - Advance src/dst by 2^size and decrement the remaining count.
  - If remaining is 0, go to DONE; else go to READ.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Copy is strictly forward, element by element. Overlap with dst>src replicates data; this is defined behaviour and is not corrected.
- `start` while not in IDLE is ignored. Command inputs are don't-care after accept.
- `mem_en`=0 in IDLE, WAIT and DONE. `mem_*` outputs are registered.

## Timing
- Reset (async assert): state IDLE; `busy`, `done`, `error`, `mem_en`, `mem_write` = 0; `mem_addr`, `mem_len`, `mem_wdata` = 0. Deassertion takes effect on the next rising edge.
- Reset mid-command: aborts immediately, with no further memory requests. Writes already done remain in memory.
- Accept edge → first READ cycle on the next cycle.
- Each element takes 2+READ_LATENCY cycles (3 at default).
- For N elements: `done` is high in cycle 3N+1 after the accept edge (default latency). Rejected or zero-length commands: `done` in cycle 1.
- `busy` is high from the cycle after accept through the DONE cycle inclusive. `start` is accepted again in the cycle after DONE.

## Structure
- Shared package `scratchpad_pkg`:
  - len encoding enum (`LEN_BYTE`, `LEN_HALF`, `LEN_WORD`, `LEN_DOUBLE`)
  - copier state enum
  - default base/size constants
  - a range-check function reused by the scratchpad assertions
- No sub-module; the FSM, address/count counters and data register live in one module.

## Test plan
All cases use BASE=16, SIZE=8, READ_LATENCY=1, with bytes 16..19 preloaded 0x11,0x22,0x33,0x44.
- Byte copy src=16 dst=20 count=4 size=00 → 4 read/write pairs; `done` at cycle 13; bytes 20..23 = 11,22,33,44; `error`=0.
- Word copy src=16 dst=20 count=4 size=10 → one element; `done` at cycle 4; word at 20 = 0x44332211.
- count=0 → no `mem_en`; `done` at cycle 1; `busy` high exactly 1 cycle.
- Rejections → `error`=1, `done` at cycle 1, zero memory requests:
  - size=01, count=3 (misaligned)
  - src=20, count=8 (out of range)
- Second `start` during a busy byte copy is ignored. `rst_l` low after the 2nd WRITE → all outputs 0 asynchronously; only bytes 20,21 changed; no `mem_en` until a new start.

Source files
------------

// File: rtl/scratchpad_pkg.sv
// Shared types and helpers for the scratchpad and its copy engine.
package scratchpad_pkg;

    typedef enum logic [1:0] {
        LEN_BYTE   = 2'b00,
        LEN_HALF   = 2'b01,
        LEN_WORD   = 2'b10,
        LEN_DOUBLE = 2'b11
    } len_e;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        WRITE,
        DONE
    } copier_state_e;

    localparam logic [63:0] DEF_SCRATCHPAD_BASE = 64'd16;
    localparam logic [63:0] DEF_SCRATCHPAD_SIZE = 64'd8;

    // Window [addr, addr+count) must sit inside [base, base+size); 65-bit sums avoid wrap.
    function automatic logic range_ok(input logic [63:0] addr, input logic [31:0] count,
                                      input logic [63:0] base, input logic [63:0] size);
        logic [64:0] win_end;
        logic [64:0] lim;
        win_end = {1'b0, addr} + {33'b0, count};
        lim     = {1'b0, base} + {1'b0, size};
        return (addr >= base) && (win_end <= lim);
    endfunction

    function automatic logic [63:0] len_mask(input len_e len);
        case (len)
            LEN_BYTE: return 64'h0000_0000_0000_00ff;
            LEN_HALF: return 64'h0000_0000_0000_ffff;
            LEN_WORD: return 64'h0000_0000_ffff_ffff;
            default:  return 64'hffff_ffff_ffff_ffff;
        endcase
    endfunction

endpackage

// File: rtl/scratchpad_copier.sv
// Copy engine: validates a command, then moves elements src->dst via read/wait/write.
// Latency: first read the cycle after accept; 2+READ_LATENCY cycles per element.
// Backpressure: none; owns the scratchpad port while busy, start ignored unless idle.
module scratchpad_copier
    import scratchpad_pkg::*;
#(
    parameter logic [63:0] SCRATCHPAD_BASE = DEF_SCRATCHPAD_BASE,
    parameter logic [63:0] SCRATCHPAD_SIZE = DEF_SCRATCHPAD_SIZE,
    parameter int          READ_LATENCY    = 1
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic        start,
    input  logic [63:0] src_addr,
    input  logic [63:0] dst_addr,
    input  logic [31:0] byte_count,
    input  logic [1:0]  size,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        mem_en,
    output logic        mem_write,
    output logic [63:0] mem_addr,
    output logic [1:0]  mem_len,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata
);

    localparam int WAIT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    copier_state_e state_q, state_d;
    logic [63:0]   src_q, src_d;
    logic [63:0]   dst_q, dst_d;
    logic [31:0]   rem_q, rem_d;
    len_e          size_q, size_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_write_q, mem_write_d;
    logic [63:0]   mem_addr_q, mem_addr_d;
    logic [1:0]    mem_len_q, mem_len_d;
    logic [63:0]   mem_wdata_q, mem_wdata_d;

    logic          cmd_ok;
    logic [31:0]   step;

    always_comb begin
        cmd_ok = ((byte_count & ((32'd1 << size) - 32'd1)) == 32'd0)
              && range_ok(src_addr, byte_count, SCRATCHPAD_BASE, SCRATCHPAD_SIZE)
              && range_ok(dst_addr, byte_count, SCRATCHPAD_BASE, SCRATCHPAD_SIZE);
        step   = 32'd1 << size_q;

        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        rem_d       = rem_q;
        size_d      = size_q;
        wait_d      = wait_q;
        error_d     = error_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    src_d   = src_addr;
                    dst_d   = dst_addr;
                    rem_d   = byte_count;
                    size_d  = len_e'(size);
                    error_d = !cmd_ok;
                    if (!cmd_ok || byte_count == 32'd0) state_d = DONE;
                    else                                state_d = READ;
                end
            end
            READ: begin
                wait_d  = WAIT_W'(READ_LATENCY - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (wait_q == '0) begin
                    mem_wdata_d = mem_rdata & len_mask(size_q);
                    state_d     = WRITE;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            WRITE: begin
                src_d   = src_q + {32'b0, step};
                dst_d   = dst_q + {32'b0, step};
                rem_d   = rem_q - step;
                state_d = (rem_d == 32'd0) ? DONE : READ;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Request outputs are registered, so derive them from the state being entered.
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
        mem_en_d    = (state_d == READ) || (state_d == WRITE);
        mem_write_d = (state_d == WRITE);
        mem_addr_d  = mem_addr_q;
        mem_len_d   = mem_len_q;
        if (mem_en_d) begin
            mem_addr_d = (state_d == WRITE) ? dst_d : src_d;
            mem_len_d  = size_d;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q     <= IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            rem_q       <= '0;
            size_q      <= LEN_BYTE;
            wait_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_len_q   <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            rem_q       <= rem_d;
            size_q      <= size_d;
            wait_q      <= wait_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            mem_en_q    <= mem_en_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_len_q   <= mem_len_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign mem_en    = mem_en_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_len   = mem_len_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_scratchpad_copier.sv
// Directed bench for scratchpad_copier against an 8-byte scratchpad model at base 16.
module tb_scratchpad_copier;

    logic        clk = 1'b0;
    logic        rst_l;
    logic        start;
    logic [63:0] src_addr;
    logic [63:0] dst_addr;
    logic [31:0] byte_count;
    logic [1:0]  size;
    logic        busy;
    logic        done;
    logic        error;
    logic        mem_en;
    logic        mem_write;
    logic [63:0] mem_addr;
    logic [1:0]  mem_len;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:7];
    logic       load;

    scratchpad_copier #(
        .SCRATCHPAD_BASE(64'd16),
        .SCRATCHPAD_SIZE(64'd8),
        .READ_LATENCY   (1)
    ) dut (
        .clk       (clk),
        .rst_l     (rst_l),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .byte_count(byte_count),
        .size      (size),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .mem_en    (mem_en),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_len   (mem_len),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Bytes outside the element (or outside the scratchpad) read back as 0xEE.
    function automatic logic [63:0] mem_read(input logic [63:0] a, input logic [1:0] l);
        logic [63:0] r;
        r = 64'hEEEE_EEEE_EEEE_EEEE;
        for (int i = 0; i < 8; i++) begin
            if (i < (1 << l) && (a + 64'(i)) >= 64'd16 && (a + 64'(i)) < 64'd24)
                r[8*i +: 8] = mem[int'(a + 64'(i) - 64'd16)];
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (load) begin
            mem[0] <= 8'h11; mem[1] <= 8'h22; mem[2] <= 8'h33; mem[3] <= 8'h44;
            mem[4] <= 8'h00; mem[5] <= 8'h00; mem[6] <= 8'h00; mem[7] <= 8'h00;
        end else if (mem_en && mem_write) begin
            for (int i = 0; i < 8; i++) begin
                if (i < (1 << mem_len) && (mem_addr + 64'(i)) >= 64'd16 && (mem_addr + 64'(i)) < 64'd24)
                    mem[int'(mem_addr + 64'(i) - 64'd16)] <= mem_wdata[8*i +: 8];
            end
        end
        if (mem_en && !mem_write) mem_rdata <= mem_read(mem_addr, mem_len);
    end

    task automatic preload();
        @(negedge clk);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Present a command so it is accepted on the next rising edge; returns in cycle 1.
    task automatic issue(input logic [63:0] s, input logic [63:0] d,
                         input logic [31:0] c, input logic [1:0] z);
        @(negedge clk);
        src_addr = s; dst_addr = d; byte_count = c; size = z; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Watch cycles 1.. until done; optionally pulse a bogus start at cycle poke.
    task automatic run(input int poke, output int done_cyc, output int en_cnt, output int busy_cnt,
                       output logic [63:0] w_dat, output logic [63:0] w_addr, output logic [1:0] r_len);
        logic seen_w;
        done_cyc = -1; en_cnt = 0; busy_cnt = 0;
        w_dat = '0; w_addr = '0; r_len = '0; seen_w = 1'b0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            @(negedge clk);
            if (mem_en) en_cnt++;
            if (busy) busy_cnt++;
            if (mem_en && !mem_write && en_cnt == 1) r_len = mem_len;
            if (mem_en && mem_write && !seen_w) begin
                w_dat = mem_wdata; w_addr = mem_addr; seen_w = 1'b1;
            end
            if (cyc == poke) begin
                start = 1'b1; src_addr = 64'd20; byte_count = 32'd8; size = 2'b00;
            end
            if (cyc == poke + 1) start = 1'b0;
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({busy, done, error, mem_en, mem_write, mem_addr, mem_len, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b done=%b err=%b en=%b wr=%b addr=%0h len=%0h wdata=%0h exp all 0",
                     busy, done, error, mem_en, mem_write, mem_addr, mem_len, mem_wdata);
        end
        @(negedge clk);
        rst_l = 1'b1;
    endtask

    task automatic test_byte_copy();
        int dc, ec, bc;
        logic [63:0] wd, wa;
        logic [1:0]  rl;
        logic [31:0] got;
        preload();
        issue(64'd16, 64'd20, 32'd4, 2'b00);
        run(2, dc, ec, bc, wd, wa, rl);
        checks++; if (dc !== 13) begin errors++; $display("FAIL byte_done_cycle got %0d exp 13", dc); end
        checks++; if (ec !== 8) begin errors++; $display("FAIL byte_mem_en_count got %0d exp 8", ec); end
        checks++; if (bc !== 13) begin errors++; $display("FAIL byte_busy_cycles got %0d exp 13", bc); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL byte_error got %b exp 0", error); end
        checks++; if (wd !== 64'h11) begin errors++; $display("FAIL byte_first_wdata got %0h exp 11", wd); end
        checks++; if (wa !== 64'd20) begin errors++; $display("FAIL byte_first_waddr got %0d exp 20", wa); end
        checks++; if (rl !== 2'b00) begin errors++; $display("FAIL byte_read_len got %0d exp 0", rl); end
        @(negedge clk);
        got = {mem[7], mem[6], mem[5], mem[4]};
        checks++; if (got !== 32'h44332211) begin errors++; $display("FAIL byte_dst_bytes got %0h exp 44332211", got); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL byte_busy_after got %b exp 0", busy); end
    endtask

    task automatic test_word_copy();
        int dc, ec, bc;
        logic [63:0] wd, wa;
        logic [1:0]  rl;
        logic [31:0] got;
        preload();
        issue(64'd16, 64'd20, 32'd4, 2'b10);
        run(0, dc, ec, bc, wd, wa, rl);
        checks++; if (dc !== 4) begin errors++; $display("FAIL word_done_cycle got %0d exp 4", dc); end
        checks++; if (ec !== 2) begin errors++; $display("FAIL word_mem_en_count got %0d exp 2", ec); end
        checks++; if (wd !== 64'h44332211) begin errors++; $display("FAIL word_wdata_masked got %0h exp 44332211", wd); end
        checks++; if (rl !== 2'b10) begin errors++; $display("FAIL word_read_len got %0d exp 2", rl); end
        @(negedge clk);
        got = {mem[7], mem[6], mem[5], mem[4]};
        checks++; if (got !== 32'h44332211) begin errors++; $display("FAIL word_dst got %0h exp 44332211", got); end
    endtask

    task automatic test_reject(input logic [63:0] s, input logic [31:0] c, input logic [1:0] z);
        int dc, ec, bc;
        logic [63:0] wd, wa;
        logic [1:0]  rl;
        issue(s, 64'd20 - ((z == 2'b00) ? 64'd4 : 64'd0), c, z);
        run(0, dc, ec, bc, wd, wa, rl);
        checks++; if (dc !== 1) begin errors++; $display("FAIL reject_done_cycle got %0d exp 1", dc); end
        checks++; if (ec !== 0) begin errors++; $display("FAIL reject_mem_en_count got %0d exp 0", ec); end
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL reject_error got %b exp 1", error); end
        repeat (3) @(negedge clk);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL reject_error_held got %b exp 1", error); end
    endtask

    task automatic test_zero_length();
        int dc, ec, bc;
        logic [63:0] wd, wa;
        logic [1:0]  rl;
        issue(64'd16, 64'd20, 32'd0, 2'b00);
        run(0, dc, ec, bc, wd, wa, rl);
        checks++; if (dc !== 1) begin errors++; $display("FAIL zero_done_cycle got %0d exp 1", dc); end
        checks++; if (ec !== 0) begin errors++; $display("FAIL zero_mem_en_count got %0d exp 0", ec); end
        checks++; if (bc !== 1) begin errors++; $display("FAIL zero_busy_cycles got %0d exp 1", bc); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL zero_error_cleared got %b exp 0", error); end
    endtask

    task automatic test_reset_mid();
        int en_after;
        logic [63:0] got;
        preload();
        issue(64'd16, 64'd20, 32'd4, 2'b00);
        repeat (6) @(negedge clk);
        checks++;
        if (!(mem_en === 1'b1 && mem_write === 1'b1 && mem_addr === 64'd21)) begin
            errors++;
            $display("FAIL mid_second_write got en=%b wr=%b addr=%0d exp 1 1 21", mem_en, mem_write, mem_addr);
        end
        @(posedge clk);
        #1;
        rst_l = 1'b0;
        #1;
        checks++;
        if ({busy, done, error, mem_en, mem_write, mem_addr, mem_len, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs got busy=%b en=%b wr=%b addr=%0h wdata=%0h exp all 0",
                     busy, mem_en, mem_write, mem_addr, mem_wdata);
        end
        @(negedge clk);
        @(negedge clk);
        rst_l = 1'b1;
        en_after = 0;
        repeat (10) begin
            @(negedge clk);
            if (mem_en) en_after++;
        end
        checks++; if (en_after !== 0) begin errors++; $display("FAIL mid_no_requests got %0d exp 0", en_after); end
        got = {mem[7], mem[6], mem[5], mem[4], mem[3], mem[2], mem[1], mem[0]};
        checks++;
        if (got !== 64'h0000_2211_4433_2211) begin
            errors++;
            $display("FAIL mid_memory got %0h exp 0000221144332211", got);
        end
    endtask

    initial begin
        rst_l = 1'b0; start = 1'b0; load = 1'b0;
        src_addr = '0; dst_addr = '0; byte_count = '0; size = '0;
        test_reset();
        test_byte_copy();
        test_word_copy();
        test_reject(64'd16, 32'd3, 2'b01);
        test_reject(64'd20, 32'd8, 2'b00);
        test_zero_length();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
